// File: rtl/npu_sram_stream_reader.sv
// Strided read-stream engine for port 2 of the operand SRAM; a small FIFO hides the 1-cycle read latency.
// Optional feature macro READER_STATS_EN adds the saturating back-pressure counter output stall_cycles.
module npu_sram_stream_reader #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int LEN_W      = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [ADDR_W-1:0] stride,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] sram_address,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [1:0]        sram_byteenable,
  output logic              sram_clken,
  input  logic [DATA_W-1:0] sram_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
`ifdef READER_STATS_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued_q;
  logic [LEN_W-1:0]  popped_q;
  logic [LEN_W-1:0]  last_idx;
  logic              inflight_q;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W:0]    occupancy;
  logic              credit_ok;
  logic              accept_start;
  logic              push, pop;

  assign sram_write      = 1'b0;
  assign sram_byteenable = 2'b11;
  assign sram_clken      = 1'b1;
  assign sram_address    = addr_q;

  assign accept_start = (state_q == S_IDLE) && start;

  // Words already committed (buffered or returning next cycle) must leave room for a new read.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign credit_ok = occupancy < (CNT_W+1)'(FIFO_DEPTH);

  assign push      = inflight_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : '0;
  assign last_idx  = len_q - LEN_W'(1);
  assign out_last  = out_valid && (popped_q == last_idx);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d         = state_q;
    sram_chipselect = 1'b0;
    busy            = 1'b0;
    done            = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (length == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy            = 1'b1;
        sram_chipselect = credit_ok;
        if (credit_ok && ((issued_q + LEN_W'(1)) == len_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        // The last word is the only one left once it reaches the head.
        if (pop && out_last && (count_q == CNT_W'(1)) && !inflight_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= sram_chipselect;
      if (accept_start) begin
        addr_q   <= start_addr;
        stride_q <= stride;
        len_q    <= length;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (sram_chipselect) begin
          addr_q   <= addr_q + stride_q;
          issued_q <= issued_q + LEN_W'(1);
        end
        if (pop) begin
          popped_q <= popped_q + LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // NOTE: storage is deliberately not reset; out_data is masked while empty so stale words never escape.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= sram_readdata;
    end
  end

`ifdef READER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (accept_start) begin
      stall_cycles <= '0;
    end else if (busy && out_valid && !out_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

  // A push landing on a full FIFO without a matching pop would lose a word.
  assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && (count_q == CNT_W'(FIFO_DEPTH))));

endmodule
